// File: rtl/modmult_sc_lat_if.sv
// Operand/result bundle for the label-aware serial modular multiplier.
interface modmult_sc_lat_if #(
  parameter int MPWID = 32
) ();
  logic [MPWID-1:0] mpand;
  logic [MPWID-1:0] mplier;
  logic [MPWID-1:0] modulus;
  logic             ds;
  logic             mpand_label;
  logic             mplier_label;
  logic             modulus_label;
  logic [MPWID-1:0] product;
  logic             ready;
  logic             busy;
  logic             product_label;

  modport master (
    output mpand, mplier, modulus, ds, mpand_label, mplier_label, modulus_label,
    input  product, ready, busy, product_label
  );

  modport slave (
    input  mpand, mplier, modulus, ds, mpand_label, mplier_label, modulus_label,
    output product, ready, busy, product_label
  );
endinterface

// File: rtl/modmult_sc_lat.sv
// Serial shift-add modular multiplier; secret-labelled operands force fixed
// MPWID-step latency so completion time is independent of secret data.
//
// state | meaning
// IDLE  | no result yet, waiting for ds
// RUN   | one shift-add step per cycle
// DONE  | product valid, waiting for ds to restart
module modmult_sc_lat #(
  parameter int MPWID     = 32,
  parameter int CT_ALWAYS = 0
) (
  input  logic              clk,
  input  logic              reset,
  modmult_sc_lat_if.slave   bus
);
  localparam int CW = (MPWID > 2) ? $clog2(MPWID) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MPWID - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [MPWID-1:0] a_q, b_q, m_q, acc_q, product_q;
  logic [CW-1:0]    cnt_q;
  logic             sec_q, label_q;

  logic             load, last_step, busy_c, ready_c;
  logic [MPWID:0]   sum_ext, sum_red, dbl_ext, dbl_red;
  logic [MPWID-1:0] acc_step, a_dbl, b_shift;

  // Datapath: each mod is one conditional subtract on an MPWID+1-bit value
  always_comb begin
    sum_ext  = {1'b0, acc_q} + {1'b0, a_q};
    sum_red  = (sum_ext >= {1'b0, m_q}) ? sum_ext - {1'b0, m_q} : sum_ext;
    dbl_ext  = {a_q, 1'b0};
    dbl_red  = (dbl_ext >= {1'b0, m_q}) ? dbl_ext - {1'b0, m_q} : dbl_ext;
    acc_step = b_q[0] ? sum_red[MPWID-1:0] : acc_q;
    a_dbl    = dbl_red[MPWID-1:0];
    b_shift  = b_q >> 1;
  end

  // Under sec only the counter may end the operation
  assign last_step = (state == S_RUN) &&
                     ((cnt_q == CNT_LAST) || (!sec_q && (b_shift == '0)));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.ds) state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  if (bus.ds) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load    = ((state == S_IDLE) || (state == S_DONE)) && bus.ds;
    busy_c  = (state == S_RUN);
    ready_c = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sec_q     <= 1'b0;
      label_q   <= 1'b0;
      product_q <= '0;
    end else if (load) begin
      a_q     <= bus.mpand;
      b_q     <= bus.mplier;
      m_q     <= bus.modulus;
      acc_q   <= '0;
      cnt_q   <= '0;
      sec_q   <= bus.mpand_label | bus.mplier_label | bus.modulus_label |
                 (CT_ALWAYS != 0);
      label_q <= bus.mpand_label | bus.mplier_label | bus.modulus_label;
    end else if (state == S_RUN) begin
      acc_q <= acc_step;
      a_q   <= a_dbl;
      b_q   <= b_shift;
      cnt_q <= cnt_q + CW'(1);
      if (last_step) product_q <= acc_step;
    end
  end

  assign bus.product       = product_q;
  assign bus.ready         = ready_c;
  assign bus.busy          = busy_c;
  assign bus.product_label = label_q;
endmodule

// File: tb/tb_modmult_sc_lat.sv
// Directed bench: label-dependent latency, product, label, reset and ds hazards,
// run against a default build and a CT_ALWAYS build in parallel.
module tb_modmult_sc_lat;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  modmult_sc_lat_if #(.MPWID(W)) bus0 ();
  modmult_sc_lat_if #(.MPWID(W)) bus1 ();

  assign bus1.mpand         = bus0.mpand;
  assign bus1.mplier        = bus0.mplier;
  assign bus1.modulus       = bus0.modulus;
  assign bus1.ds            = bus0.ds;
  assign bus1.mpand_label   = bus0.mpand_label;
  assign bus1.mplier_label  = bus0.mplier_label;
  assign bus1.modulus_label = bus0.modulus_label;

  modmult_sc_lat #(.MPWID(W), .CT_ALWAYS(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  modmult_sc_lat #(.MPWID(W), .CT_ALWAYS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [W-1:0] prod;
    logic         lbl;
    int           k;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, b, m);
    int unsigned p;
    p = (int'(a) * int'(b)) % int'(m);
    return p[W-1:0];
  endfunction

  function automatic int ref_k(input logic [W-1:0] b, input logic sec);
    int k;
    if (sec) return W;
    k = 1;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  task automatic set_ops(input logic [W-1:0] a, b, m, input logic la, lb, lm);
    bus0.mpand = a; bus0.mplier = b; bus0.modulus = m;
    bus0.mpand_label = la; bus0.mplier_label = lb; bus0.modulus_label = lm;
  endtask

  // One operation: both builds start together; ds optionally re-pulsed mid-RUN
  task automatic do_op(input string tag, input logic [W-1:0] a, b, m,
                       input logic la, lb, lm, input bit disturb);
    exp_t e;
    int lat0, lat1, busy_cnt;
    logic [W-1:0] prod1;
    set_ops(a, b, m, la, lb, lm);
    bus0.ds = 1'b1;
    sb.push_back('{ref_mod(a, b, m), la | lb | lm, ref_k(b, la | lb | lm)});
    @(posedge clk); #1;
    bus0.ds = 1'b0;
    lat0 = 0; lat1 = 0; prod1 = '0;
    busy_cnt = bus0.busy ? 1 : 0;
    for (int c = 1; c <= 20 && (lat0 == 0 || lat1 == 0); c++) begin
      @(posedge clk); #1;
      if (disturb && c == 3) begin
        set_ops(8'h01, 8'hff, 8'hfb, 1'b0, 1'b0, 1'b0);
        bus0.ds = 1'b1;
      end
      if (disturb && c == 4) bus0.ds = 1'b0;
      if (lat0 == 0) begin
        if (bus0.ready) begin
          lat0 = c;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_prod"}, 32'(bus0.product), 32'(e.prod));
            chk({tag, "_label"}, 32'(bus0.product_label), 32'(e.lbl));
            chk({tag, "_lat"}, 32'(lat0), 32'(e.k));
            chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.k));
          end
        end else if (bus0.busy) busy_cnt++;
      end
      if (lat1 == 0 && bus1.ready) begin
        lat1 = c;
        prod1 = bus1.product;
      end
    end
    if (lat0 == 0) chk({tag, "_timeout"}, 32'(lat0), 32'(ref_k(b, la | lb | lm)));
    chk({tag, "_ct_lat"}, 32'(lat1), 32'(W));
    chk({tag, "_ct_prod"}, 32'(prod1), 32'(ref_mod(a, b, m)));
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    bus0.ds = 1'b0;
    set_ops('0, '0, 8'd1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_product", 32'(bus0.product), 32'd0);
    chk("rst_ready", 32'(bus0.ready), 32'd0);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_label", 32'(bus0.product_label), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op("pub_5x3", 8'd5, 8'd3, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sec_5x3", 8'd5, 8'd3, 8'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("sec_x80", 8'd5, 8'h80, 8'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("sec_x01", 8'd5, 8'h01, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("pub_x80", 8'd5, 8'h80, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("pub_zero", 8'd3, 8'd0, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("overflow", 8'd250, 8'd255, 8'd251, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sec_mod", 8'd100, 8'd9, 8'd201, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset three steps into a secret operation
    set_ops(8'd5, 8'd3, 8'd7, 1'b1, 1'b0, 1'b0);
    bus0.ds = 1'b1;
    @(posedge clk); #1;
    bus0.ds = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bus0.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_ready", 32'(bus0.ready), 32'd0);
    chk("midrst_busy", 32'(bus0.busy), 32'd0);
    chk("midrst_product", 32'(bus0.product), 32'd0);
    chk("midrst_label", 32'(bus0.product_label), 32'd0);
    chk("midrst_ct_busy", 32'(bus1.busy), 32'd0);
    do_op("after_rst", 8'd6, 8'd6, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0);

    do_op("ds_in_run", 8'd4, 8'd5, 8'd9, 1'b0, 1'b1, 1'b0, 1'b1);

    // ds held high: public k=2 restarts every k+1 cycles
    set_ops(8'd5, 8'd3, 8'd7, 1'b0, 1'b0, 1'b0);
    bus0.ds = 1'b1;
    sb.push_back('{8'd1, 1'b0, 2});
    @(posedge clk); #1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      chk("b2b_ready", 32'(bus0.ready), 32'((c % 3) == 2));
      if (bus0.ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("b2b_prod", 32'(bus0.product), 32'(e.prod));
      end
      if (c == 3 || c == 6) sb.push_back('{8'd1, 1'b0, 2});
    end
    bus0.ds = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
